// File: rtl/bsc_skid_buffer_pkg.sv
// Shared bluespec primitive types: occupancy states for the skid buffer and later FIFO primitives.
// The state encoding equals the number of held items.
package bsc_skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bsc_fifo_state_e;

    localparam int unsigned BSC_SKID_DEPTH = 2;

    function automatic logic [1:0] bsc_fifo_count(input bsc_fifo_state_e st);
        return logic'(st == FULL) ? 2'd2 : (st == ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/bsc_skid_buffer_if.sv
// Valid/ready handshake bundle around a skid buffer: upstream push side, downstream pop side, occupancy.
interface bsc_skid_buffer_if #(
    parameter int WIDTH = 1
) (
    input logic clk
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    // Buffer side.
    modport slave (
        input  clk, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    // Producer/consumer side.
    modport master (
        input  clk, in_ready, out_valid, out_data, count,
        output in_valid, in_data, out_ready
    );
endinterface

// File: rtl/bsc_skid_buffer.sv
// Two-entry skid buffer: fully registered valid/ready stage with no combinational
// path between the upstream and downstream handshakes.
module bsc_skid_buffer
    import bsc_skid_buffer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    bsc_fifo_state_e  state;
    bsc_fifo_state_e  state_next;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             enq;
    logic             deq;

    assign enq = in_valid && in_ready;
    assign deq = out_valid && out_ready;

    always_comb begin
        // NOTE: default assignment first, so every path writes state_next and no latch is inferred.
        state_next = state;
        case (state)
            EMPTY: if (enq) state_next = ONE;
            ONE: begin
                if (enq && !deq)      state_next = FULL;
                else if (deq && !enq) state_next = EMPTY;
            end
            FULL:    if (deq) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so both sides see flop outputs only.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state, so every flop samples pre-edge values.
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
        end
    end

    // NOTE: payload registers carry no reset; occupancy alone decides whether their contents matter.
    always_ff @(posedge clk) begin
        case (state)
            EMPTY: if (enq) main_data <= in_data;
            ONE: begin
                if (enq && deq)  main_data <= in_data;
                else if (enq)    skid_data <= in_data;
            end
            FULL:    if (deq) main_data <= skid_data;
            default: ;
        endcase
    end

    assign out_data = main_data;
    assign count    = bsc_fifo_count(state);

endmodule

`ifdef __BSC_TESTBENCH__
// Free-running self-test: pseudo-random valid/ready traffic carrying an incrementing
// sequence; fail latches on any out-of-order item, pass once 255 items arrive intact.
module bsc_skid_buffer_test001 (
    input  logic clk,
    input  logic rst,
    output logic pass,
    output logic fail
);
    logic [3:0] lfsr;
    logic [7:0] send_val;
    logic [7:0] exp_val;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] count;

    bsc_skid_buffer #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (lfsr[0]),
        .in_ready  (in_ready),
        .in_data   (send_val),
        .out_valid (out_valid),
        .out_ready (lfsr[1]),
        .out_data  (out_data),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= 4'b1001;
            send_val <= 8'd0;
            exp_val  <= 8'd0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            if (lfsr[0] && in_ready) send_val <= send_val + 8'd1;
            if (out_valid && lfsr[1]) begin
                if (out_data != exp_val) fail <= 1'b1;
                if (exp_val == 8'hfe)    pass <= 1'b1;
                exp_val <= exp_val + 8'd1;
            end
        end
    end
endmodule
`endif

// File: tb/tb_bsc_skid_buffer.sv
// Self-checking bench for bsc_skid_buffer: queue-based occupancy model compared every
// cycle, plus directed reset, single-pass, stall, streaming and mid-operation reset cases.
module tb_bsc_skid_buffer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bsc_skid_buffer_if #(.WIDTH(WIDTH)) bus (.clk(clk));

    bsc_skid_buffer #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (bus.in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .count     (bus.count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of at most two items; accept when fewer than two are held,
    // release the head whenever one is held and the consumer is ready.
    logic [WIDTH-1:0] mq[$];
    bit               model_on = 1'b0;

    always @(posedge clk) begin
        bit do_deq;
        bit do_enq;
        if (rst) begin
            mq.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            do_deq = (mq.size() > 0) && bus.out_ready;
            do_enq = bus.in_valid && (mq.size() < 2);
            if (do_deq) void'(mq.pop_front());
            if (do_enq) mq.push_back(bus.in_data);
        end
    end

    // Items the consumer actually took, in order.
    logic [WIDTH-1:0] rx[$];

    always @(negedge clk) begin
        if (model_on) begin
            check("cmp_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            check("cmp_in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
            check("cmp_count", 32'(bus.count), 32'(mq.size()));
            if (mq.size() > 0) check("cmp_out_data", 32'(bus.out_data), 32'(mq[0]));
        end
        if (!rst && bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [WIDTH-1:0] exp_fill [3] = '{8'h01, 8'h02, 8'h03};

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_count", 32'(bus.count), 32'd0);

        // Single pass.
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("single_out_valid", 32'(bus.out_valid), 32'd1);
        check("single_out_data", 32'(bus.out_data), 32'hA5);
        check("single_count", 32'(bus.count), 32'd1);
        tick();
        check("single_drained_count", 32'(bus.count), 32'd0);
        check("single_drained_valid", 32'(bus.out_valid), 32'd0);
        check("single_rx_size", 32'(rx.size()), 32'd1);
        check("single_rx_data", (rx.size() > 0) ? 32'(rx[0]) : 32'hdead, 32'hA5);
        rx.delete();

        // Fill and stall.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01;
        tick();
        bus.in_data = 8'h02;
        tick();
        check("fill_count", 32'(bus.count), 32'd2);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_head", 32'(bus.out_data), 32'h01);
        bus.in_data = 8'h03;
        tick();
        check("stall_count", 32'(bus.count), 32'd2);
        check("stall_head", 32'(bus.out_data), 32'h01);
        bus.out_ready = 1'b1;
        tick();
        check("release_count", 32'(bus.count), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("fill_drained_count", 32'(bus.count), 32'd0);
        check("fill_rx_size", 32'(rx.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("fill_order", (i < rx.size()) ? 32'(rx[i]) : 32'hdead, 32'(exp_fill[i]));
        rx.delete();

        // Streaming at full rate.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'(i);
            tick();
            check("stream_count_le1", 32'(bus.count <= 2'd1), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_rx_size", 32'(rx.size()), 32'd100);
        for (int i = 0; i < 100; i++)
            check("stream_order", (i < rx.size()) ? 32'(rx[i]) : 32'hdead, 32'(i));
        rx.delete();

        // Reset while full; the enqueue offered during reset must be ignored.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        tick();
        bus.in_data = 8'h22;
        tick();
        check("midrst_full_count", 32'(bus.count), 32'd2);
        rst         = 1'b1;
        bus.in_data = 8'h33;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("midrst_no_stale", 32'(rx.size()), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h44;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("midrst_new_size", 32'(rx.size()), 32'd1);
        check("midrst_new_data", (rx.size() > 0) ? 32'(rx[0]) : 32'hdead, 32'h44);
        rx.delete();

        // Random valid/backpressure; the per-cycle model compare does the checking.
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data   = WIDTH'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
